// File: rtl/param_sync_fifo.sv
// ============================================================================
// Module      : param_sync_fifo
// Description : Single-clock FIFO with occupancy flags, error pulses and
//               selectable registered-read or first-word-fall-through output.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module param_sync_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = 4,
    parameter int AF_LEVEL   = 14,
    parameter int AE_LEVEL   = 2,
    parameter int FWFT       = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  rd_valid,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam logic [ADDR_WIDTH:0]   C_DEPTH = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0]   C_AF    = (ADDR_WIDTH+1)'(AF_LEVEL);
    localparam logic [ADDR_WIDTH:0]   C_AE    = (ADDR_WIDTH+1)'(AE_LEVEL);
    localparam logic [ADDR_WIDTH-1:0] C_PTR_1 = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH:0]   C_CNT_1 = (ADDR_WIDTH+1)'(1);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic                  overflow_q, underflow_q;

    logic w_full, w_empty, w_wr_acc, w_rd_acc;

    // Accept decisions use the pre-edge flags; reset low blocks every access.
    always_comb begin
        w_full   = (count_q == C_DEPTH);
        w_empty  = (count_q == '0);
        w_wr_acc = wr_en & ~w_full & reset;
        w_rd_acc = rd_en & ~w_empty & reset;

        wr_ptr_d = w_wr_acc ? (wr_ptr_q + C_PTR_1) : wr_ptr_q;
        rd_ptr_d = w_rd_acc ? (rd_ptr_q + C_PTR_1) : rd_ptr_q;

        count_d = count_q;
        case ({w_wr_acc, w_rd_acc})
            2'b10:   count_d = count_q + C_CNT_1;
            2'b01:   count_d = count_q - C_CNT_1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= wr_en & w_full;
            underflow_q <= rd_en & w_empty;
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (w_wr_acc) begin
            mem_q[wr_ptr_q] <= data_in;
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign data_out = w_empty ? '0 : mem_q[rd_ptr_q];
            assign rd_valid = ~w_empty;
        end else begin : g_reg_read
            logic [DATA_WIDTH-1:0] data_q;
            logic                  rd_valid_q;

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    data_q     <= '0;
                    rd_valid_q <= 1'b0;
                end else begin
                    rd_valid_q <= w_rd_acc;
                    if (w_rd_acc) begin
                        data_q <= mem_q[rd_ptr_q];
                    end
                end
            end

            assign data_out = data_q;
            assign rd_valid = rd_valid_q;
        end
    endgenerate

    assign full         = w_full;
    assign empty        = w_empty;
    assign almost_full  = (count_q >= C_AF);
    assign almost_empty = (count_q <= C_AE);
    assign count        = count_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

endmodule

`default_nettype wire

// File: tb/tb_param_sync_fifo.sv
// ============================================================================
// Module      : tb_param_sync_fifo
// Description : Scoreboard bench for param_sync_fifo in both output modes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_param_sync_fifo;

    logic       clk = 1'b0;
    logic       reset;
    logic       wr_en = 1'b0, rd_en = 1'b0;
    logic [7:0] data_in = '0;
    logic [7:0] data_out;
    logic       rd_valid, full, empty, almost_full, almost_empty, overflow, underflow;
    logic [4:0] count;

    logic       f_wr = 1'b0, f_rd = 1'b0;
    logic [7:0] f_din = '0;
    logic [7:0] f_dout;
    logic       f_rvalid, f_full, f_empty, f_af, f_ae, f_ovf, f_unf;
    logic [4:0] f_count;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    int         m_cnt = 0;
    logic       m_acc_r, m_ovf, m_unf;
    logic [7:0] sb[$];
    logic [7:0] exp_d;
    logic [7:0] last_d = '0;

    always #5 clk = ~clk;

    param_sync_fifo #(.FWFT(0)) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .rd_en(rd_en), .data_in(data_in),
        .data_out(data_out), .rd_valid(rd_valid), .full(full), .empty(empty),
        .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
        .overflow(overflow), .underflow(underflow)
    );

    param_sync_fifo #(.FWFT(1)) dut_fwft (
        .clk(clk), .reset(reset), .wr_en(f_wr), .rd_en(f_rd), .data_in(f_din),
        .data_out(f_dout), .rd_valid(f_rvalid), .full(f_full), .empty(f_empty),
        .almost_full(f_af), .almost_empty(f_ae), .count(f_count),
        .overflow(f_ovf), .underflow(f_unf)
    );

    // One clock of stimulus on the mode-0 FIFO; the model records what must happen.
    task automatic cyc(input logic w, input logic r, input logic [7:0] d);
        logic acc_w;
        wr_en   = w;
        rd_en   = r;
        data_in = d;
        acc_w   = w && (m_cnt != 16);
        m_acc_r = r && (m_cnt != 0);
        m_ovf   = w && (m_cnt == 16);
        m_unf   = r && (m_cnt == 0);
        if (acc_w) sb.push_back(d);
        m_cnt = m_cnt + (acc_w ? 1 : 0) - (m_acc_r ? 1 : 0);
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #3;
        checks++;
        if ({count, empty, full, almost_empty, almost_full} !== {5'd0, 1'b1, 1'b0, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL reset_flags: got cnt=%0d e=%b f=%b ae=%b af=%b exp cnt=0 e=1 f=0 ae=1 af=0",
                     count, empty, full, almost_empty, almost_full);
        end
        checks++;
        if ({data_out, rd_valid, overflow, underflow} !== 11'd0) begin
            failures++;
            $display("FAIL reset_outputs: got d=%h v=%b ovf=%b unf=%b exp all zero",
                     data_out, rd_valid, overflow, underflow);
        end
        checks++;
        if ({f_dout, f_rvalid, f_empty} !== {8'h00, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL reset_fwft: got d=%h v=%b e=%b exp d=00 v=0 e=1", f_dout, f_rvalid, f_empty);
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_fill_drain();
        for (int i = 1; i <= 16; i++) begin
            cyc(1'b1, 1'b0, 8'(i));
            checks++;
            if (count !== 5'(m_cnt) || full !== (i == 16) || almost_full !== (i >= 14) ||
                almost_empty !== (i <= 2) || empty !== 1'b0 || overflow !== 1'b0) begin
                failures++;
                $display("FAIL fill_step%0d: got cnt=%0d f=%b af=%b ae=%b e=%b ovf=%b exp cnt=%0d f=%b af=%b ae=%b e=0 ovf=0",
                         i, count, full, almost_full, almost_empty, empty, overflow,
                         m_cnt, i == 16, i >= 14, i <= 2);
            end
        end
        cyc(1'b1, 1'b0, 8'h11);
        checks++;
        if (overflow !== m_ovf || count !== 5'd16 || full !== 1'b1) begin
            failures++;
            $display("FAIL overflow_pulse: got ovf=%b cnt=%0d f=%b exp ovf=1 cnt=16 f=1", overflow, count, full);
        end
        cyc(1'b0, 1'b0, 8'h00);
        checks++;
        if (overflow !== 1'b0) begin
            failures++;
            $display("FAIL overflow_one_cycle: got ovf=%b exp 0", overflow);
        end
        for (int i = 0; i < 16; i++) begin
            cyc(1'b0, 1'b1, 8'h00);
            exp_d  = sb.pop_front();
            last_d = exp_d;
            checks++;
            if (rd_valid !== 1'b1 || data_out !== exp_d || count !== 5'(m_cnt)) begin
                failures++;
                $display("FAIL drain_read%0d: got v=%b d=%h cnt=%0d exp v=1 d=%h cnt=%0d",
                         i, rd_valid, data_out, count, exp_d, m_cnt);
            end
        end
        cyc(1'b0, 1'b0, 8'h00);
        checks++;
        if (rd_valid !== 1'b0 || data_out !== last_d || empty !== 1'b1) begin
            failures++;
            $display("FAIL drain_idle: got v=%b d=%h e=%b exp v=0 d=%h e=1", rd_valid, data_out, empty, last_d);
        end
        cyc(1'b0, 1'b1, 8'h00);
        checks++;
        if (underflow !== m_unf || rd_valid !== 1'b0 || data_out !== last_d || count !== 5'd0) begin
            failures++;
            $display("FAIL underflow_pulse: got unf=%b v=%b d=%h cnt=%0d exp unf=1 v=0 d=%h cnt=0",
                     underflow, rd_valid, data_out, count, last_d);
        end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 10; i++) cyc(1'b1, 1'b0, 8'(8'h20 + i));
        for (int i = 0; i < 10; i++) begin
            cyc(1'b0, 1'b1, 8'h00);
            exp_d  = sb.pop_front();
            last_d = exp_d;
            checks++;
            if (rd_valid !== 1'b1 || data_out !== exp_d) begin
                failures++;
                $display("FAIL wrap_pre%0d: got v=%b d=%h exp v=1 d=%h", i, rd_valid, data_out, exp_d);
            end
        end
        for (int i = 0; i < 16; i++) cyc(1'b1, 1'b0, 8'(8'hA0 + i));
        checks++;
        if (full !== 1'b1 || count !== 5'd16) begin
            failures++;
            $display("FAIL wrap_full: got f=%b cnt=%0d exp f=1 cnt=16", full, count);
        end
        for (int i = 0; i < 16; i++) begin
            cyc(1'b0, 1'b1, 8'h00);
            exp_d  = sb.pop_front();
            last_d = exp_d;
            checks++;
            if (rd_valid !== 1'b1 || data_out !== exp_d) begin
                failures++;
                $display("FAIL wrap_read%0d: got v=%b d=%h exp v=1 d=%h", i, rd_valid, data_out, exp_d);
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, 8'(8'h60 + i));
        for (int i = 0; i < 20; i++) begin
            cyc(1'b1, 1'b1, 8'(8'h80 + i));
            exp_d  = sb.pop_front();
            last_d = exp_d;
            checks++;
            if (count !== 5'd8 || overflow !== 1'b0 || underflow !== 1'b0 ||
                rd_valid !== 1'b1 || data_out !== exp_d) begin
                failures++;
                $display("FAIL b2b_cycle%0d: got cnt=%0d ovf=%b unf=%b v=%b d=%h exp cnt=8 ovf=0 unf=0 v=1 d=%h",
                         i, count, overflow, underflow, rd_valid, data_out, exp_d);
            end
        end
        for (int i = 0; i < 8; i++) begin
            cyc(1'b0, 1'b1, 8'h00);
            exp_d  = sb.pop_front();
            last_d = exp_d;
            checks++;
            if (data_out !== exp_d) begin
                failures++;
                $display("FAIL b2b_tail%0d: got d=%h exp d=%h", i, data_out, exp_d);
            end
        end
    endtask

    task automatic test_simul_edges();
        cyc(1'b1, 1'b1, 8'h5A);
        checks++;
        if (count !== 5'd1 || underflow !== m_unf || rd_valid !== 1'b0 || data_out !== last_d) begin
            failures++;
            $display("FAIL simul_empty: got cnt=%0d unf=%b v=%b d=%h exp cnt=1 unf=1 v=0 d=%h",
                     count, underflow, rd_valid, data_out, last_d);
        end
        cyc(1'b0, 1'b1, 8'h00);
        exp_d  = sb.pop_front();
        last_d = exp_d;
        checks++;
        if (data_out !== exp_d || rd_valid !== 1'b1 || empty !== 1'b1) begin
            failures++;
            $display("FAIL simul_empty_read: got d=%h v=%b e=%b exp d=%h v=1 e=1", data_out, rd_valid, empty, exp_d);
        end
        for (int i = 0; i < 16; i++) cyc(1'b1, 1'b0, 8'(8'hC0 + i));
        cyc(1'b1, 1'b1, 8'hEE);
        exp_d  = sb.pop_front();
        last_d = exp_d;
        checks++;
        if (count !== 5'd15 || overflow !== m_ovf || rd_valid !== 1'b1 || data_out !== exp_d) begin
            failures++;
            $display("FAIL simul_full: got cnt=%0d ovf=%b v=%b d=%h exp cnt=15 ovf=1 v=1 d=%h",
                     count, overflow, rd_valid, data_out, exp_d);
        end
        for (int i = 0; i < 15; i++) begin
            cyc(1'b0, 1'b1, 8'h00);
            exp_d  = sb.pop_front();
            last_d = exp_d;
            checks++;
            if (data_out !== exp_d) begin
                failures++;
                $display("FAIL simul_full_drain%0d: got d=%h exp d=%h", i, data_out, exp_d);
            end
        end
    endtask

    task automatic test_fwft();
        f_wr  = 1'b1;
        f_din = 8'h3C;
        @(posedge clk); #1;
        f_wr = 1'b0;
        checks++;
        if (f_dout !== 8'h3C || f_rvalid !== 1'b1 || f_empty !== 1'b0 || f_count !== 5'd1) begin
            failures++;
            $display("FAIL fwft_fall: got d=%h v=%b e=%b cnt=%0d exp d=3c v=1 e=0 cnt=1", f_dout, f_rvalid, f_empty, f_count);
        end
        @(posedge clk); #1;
        checks++;
        if (f_dout !== 8'h3C || f_rvalid !== 1'b1) begin
            failures++;
            $display("FAIL fwft_hold: got d=%h v=%b exp d=3c v=1", f_dout, f_rvalid);
        end
        f_rd = 1'b1;
        @(posedge clk); #1;
        f_rd = 1'b0;
        checks++;
        if (f_empty !== 1'b1 || f_rvalid !== 1'b0 || f_count !== 5'd0) begin
            failures++;
            $display("FAIL fwft_pop: got e=%b v=%b cnt=%0d exp e=1 v=0 cnt=0", f_empty, f_rvalid, f_count);
        end
        f_wr = 1'b1; f_din = 8'h11;
        @(posedge clk); #1;
        f_din = 8'h22;
        @(posedge clk); #1;
        f_wr = 1'b0; f_rd = 1'b1;
        checks++;
        if (f_dout !== 8'h11 || f_count !== 5'd2) begin
            failures++;
            $display("FAIL fwft_head: got d=%h cnt=%0d exp d=11 cnt=2", f_dout, f_count);
        end
        @(posedge clk); #1;
        checks++;
        if (f_dout !== 8'h22 || f_rvalid !== 1'b1) begin
            failures++;
            $display("FAIL fwft_next: got d=%h v=%b exp d=22 v=1", f_dout, f_rvalid);
        end
        @(posedge clk); #1;
        f_rd = 1'b0;
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 10; i++) cyc(1'b1, 1'b0, 8'(8'h30 + i));
        cyc(1'b0, 1'b1, 8'h00);
        exp_d = sb.pop_front();
        checks++;
        if (count !== 5'd9 || data_out !== exp_d || rd_valid !== 1'b1) begin
            failures++;
            $display("FAIL areset_setup: got cnt=%0d d=%h v=%b exp cnt=9 d=%h v=1", count, data_out, rd_valid, exp_d);
        end
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (count !== 5'd0 || empty !== 1'b1 || data_out !== 8'h00 || rd_valid !== 1'b0 || full !== 1'b0) begin
            failures++;
            $display("FAIL areset_immediate: got cnt=%0d e=%b d=%h v=%b f=%b exp cnt=0 e=1 d=00 v=0 f=0",
                     count, empty, data_out, rd_valid, full);
        end
        wr_en   = 1'b1;
        data_in = 8'h99;
        @(posedge clk); #1;
        wr_en = 1'b0;
        checks++;
        if (count !== 5'd0 || empty !== 1'b1) begin
            failures++;
            $display("FAIL areset_blocks_write: got cnt=%0d e=%b exp cnt=0 e=1", count, empty);
        end
        @(negedge clk);
        reset = 1'b1;
        sb.delete();
        m_cnt  = 0;
        last_d = 8'h00;
        cyc(1'b1, 1'b0, 8'h77);
        checks++;
        if (count !== 5'd1) begin
            failures++;
            $display("FAIL areset_first_write: got cnt=%0d exp 1", count);
        end
        cyc(1'b0, 1'b1, 8'h00);
        exp_d = sb.pop_front();
        checks++;
        if (data_out !== exp_d || rd_valid !== 1'b1 || empty !== 1'b1) begin
            failures++;
            $display("FAIL areset_first_read: got d=%h v=%b e=%b exp d=%h v=1 e=1", data_out, rd_valid, empty, exp_d);
        end
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_wrap();
        test_back_to_back();
        test_simul_edges();
        test_fwft();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/param_sync_fifo.md
PARAM_SYNC_FIFO -- requirements
Module: param_sync_fifo

Interface
REQ-001 Parameter DATA_WIDTH, default 8, word width in bits (>=1).
REQ-002 Parameter DEPTH, default 16, number of entries; power of two, >=2.
REQ-003 Parameter ADDR_WIDTH, default 4, pointer width; SHALL equal log2(DEPTH).
REQ-004 Parameter AF_LEVEL, default 14, almost_full threshold; 1..DEPTH-1.
REQ-005 Parameter AE_LEVEL, default 2, almost_empty threshold; 1..DEPTH-1.
REQ-006 Parameter FWFT, default 0; 0 = registered-read mode, 1 = first-word-fall-through mode.
REQ-007 clk  input  1  single clock; all state changes on rising edge.
REQ-008 reset  input  1  asynchronous, active-low reset (0 = in reset).
REQ-009 wr_en  input  1  write request.
REQ-010 rd_en  input  1  read request (FWFT: pop/acknowledge of head word).
REQ-011 data_in  input  DATA_WIDTH  write data.
REQ-012 data_out  output  DATA_WIDTH  read data.
REQ-013 rd_valid  output  1  data_out holds a newly read word (mode 0); equals !empty (mode 1).
REQ-014 full, empty  output  1 each  occupancy flags.
REQ-015 almost_full, almost_empty  output  1 each  threshold flags.
REQ-016 count  output  ADDR_WIDTH+1  current occupancy, 0..DEPTH.
REQ-017 overflow, underflow  output  1 each  one-cycle error pulses.

Function
REQ-018 Write accepted iff wr_en=1 and full=0; word stored at wr_ptr, wr_ptr increments modulo DEPTH.
REQ-019 Read accepted iff rd_en=1 and empty=0; rd_ptr increments modulo DEPTH.
REQ-020 Accept decisions SHALL use flag values before the edge; a rejected write on full SHALL NOT be rescued by a same-cycle read.
REQ-021 count next = count + acc_wr - acc_rd; simultaneous accepted read and write leaves count unchanged (no last-assignment-wins loss).
REQ-022 full = (count==DEPTH), empty = (count==0), almost_full = (count>=AF_LEVEL), almost_empty = (count<=AE_LEVEL); all decoded from registered count, valid in the same cycle count updates.
REQ-023 Pointers wrap DEPTH-1 -> 0 with no gap; FIFO order preserved across any number of wraps.
REQ-024 Mode 0: on accepted read, data_out registers mem[rd_ptr] at that edge; rd_valid=1 for exactly the following cycle; data_out holds its value otherwise.
REQ-025 Mode 1: data_out = mem[rd_ptr] whenever empty=0 (no registered stage); word written to empty FIFO at edge N is on data_out and rd_valid=1 after edge N.
REQ-026 overflow pulses 1 for one cycle after an edge where wr_en=1 and full=1; underflow likewise for rd_en=1 and empty=1.
REQ-027 Rejected accesses SHALL NOT change pointers, count, memory or data_out.
REQ-028 Simultaneous write and read on empty FIFO: write accepted, read rejected, underflow pulses, count becomes 1.
REQ-029 Simultaneous write and read on full FIFO: read accepted, write rejected, overflow pulses, count becomes DEPTH-1.

Reset
REQ-030 reset=0 SHALL immediately (without clock) clear wr_ptr, rd_ptr, count, data_out, rd_valid, overflow, underflow; empty=1, almost_empty=1, full=0, almost_full=0.
REQ-031 Memory contents are not reset; contents after reset are undefined and unobservable until rewritten.
REQ-032 Reset asserted mid-transfer discards all stored words; no access is accepted while reset=0.
REQ-033 First access SHALL be accepted on the first rising edge after reset deasserts.

Verification
REQ-034 Defaults, mode 0: write 0x01..0x10 (16 words) -> full=1 after 16th edge, almost_full=1 after 14th; 17th write -> overflow pulse, count stays 16; 16 reads return 0x01..0x10 in order, rd_valid each following cycle, empty=1 at end.
REQ-035 Wrap: fill 10, drain 10, fill 16 values 0xA0..0xAF -> full=1, read order 0xA0..0xAF, pointers wrapped once.
REQ-036 count=8, wr_en=rd_en=1 for 20 cycles -> count stays 8, no error pulses, output stream is input stream delayed by 8 words.
REQ-037 Empty, wr_en=rd_en=1 with data 0x5A -> count=1, underflow pulse, next read returns 0x5A; full case symmetric with overflow pulse, count=15.
REQ-038 FWFT=1: write 0x3C to empty FIFO -> data_out=0x3C and rd_valid=1 after that edge without rd_en; rd_en pop -> empty=1.
REQ-039 Async reset with count=9, asserted between clock edges -> count=0, empty=1, data_out=0 before next edge; first post-reset write/read returns the new word.
